// File: rtl/count_event_monitor_pkg.sv
// Shared types for the count event monitor: event classes and payload field widths.
package count_event_monitor_pkg;

    localparam int EVT_CODE_W = 2;

    typedef enum logic [EVT_CODE_W-1:0] {
        STEP  = 2'b00,
        WRAP  = 2'b01,
        CLEAR = 2'b10,
        JUMP  = 2'b11
    } evt_code_t;

endpackage : count_event_monitor_pkg

// File: rtl/event_fifo.sv
// Synchronous FIFO with a registered head entry; accepts a push into a full FIFO
// only when a pop happens on the same edge.
module event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      used;
    logic [WIDTH-1:0] head;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (used == '0);
    assign full    = (used == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_nxt  = rd_ptr + AW'(1);
    assign dout    = head;

    // NOTE: storage is deliberately not reset; the pointers and the head register
    // carry all observable state, so the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_nxt;
            end
            case ({push_ok, pop_ok})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: used <= used;
            endcase
            // Head tracks the entry at the read pointer after this edge.
            if (pop_ok) begin
                if (used > (AW+1)'(1)) begin
                    head <= mem[rd_nxt];
                end else if (push_ok) begin
                    head <= din;
                end
            end else if (empty && push_ok) begin
                head <= din;
            end
        end
    end

endmodule : event_fifo

// File: rtl/count_event_monitor.sv
// Watches a counter bus, classifies each change (STEP/WRAP/CLEAR/JUMP) and queues
// events for a valid/ready consumer. Define COUNT_EVENT_MONITOR_TS_EN for timestamps.
module count_event_monitor
    import count_event_monitor_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE-1:0]       count,
    input  logic                  evt_ready,
    input  logic                  clear_ovf,
    output logic                  evt_valid,
    output logic [EVT_CODE_W-1:0] evt_code,
    output logic [SIZE-1:0]       evt_value,
`ifdef COUNT_EVENT_MONITOR_TS_EN
    output logic [TS_W-1:0]       evt_ts,
`endif
    output logic                  overflow
);

`ifdef COUNT_EVENT_MONITOR_TS_EN
    localparam int ENTRY_W = EVT_CODE_W + SIZE + TS_W;
`else
    // TS_W stays in the parameter list so both builds share one instance signature.
    localparam int ENTRY_W = EVT_CODE_W + SIZE + 0 * TS_W;
`endif

    localparam logic [SIZE-1:0] ALL_ONES = '1;

    logic [SIZE-1:0]    prev;
    logic               prev_vld;
    evt_code_t          code;
    logic               push;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_out;

    // WRAP outranks CLEAR and STEP: an all-ones to zero transition is always a wrap.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        code = JUMP;
        if (prev == ALL_ONES && count == '0) begin
            code = WRAP;
        end else if (count == '0 && prev != '0) begin
            code = CLEAR;
        end else if (count == prev + SIZE'(1)) begin
            code = STEP;
        end
    end

    assign push = prev_vld && (count != prev);
    assign pop  = evt_valid && evt_ready;
    assign drop = push && fifo_full && !pop;

`ifdef COUNT_EVENT_MONITOR_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign entry_in = {code, count, ts_cnt};
    assign {evt_code, evt_value, evt_ts} = entry_out;
`else
    assign entry_in = {code, count};
    assign {evt_code, evt_value} = entry_out;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= '0;
            prev_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            prev     <= count;
            prev_vld <= 1'b1;
            // A drop in the same cycle as a clear request keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry_in),
        .pop   (pop),
        .dout  (entry_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;

endmodule : count_event_monitor

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream consumer of the `binary_counter` output. Samples the `count` bus every cycle and classifies each change as a step, wrap, clear or jump. Each event is buffered in a small FIFO and presented on a valid/ready port to the next stage (logger or display controller). Dropped events are flagged by a sticky overflow bit.

## Interface
- `SIZE`, 4, width of the monitored count bus (≥2)
- `DEPTH`, 4, event FIFO depth (power of two, ≥2)
- `TS_W`, 16, timestamp width (used only with `COUNT_EVENT_MONITOR_TS_EN`)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `count`  in  SIZE  count bus driven by `binary_counter`
- `evt_ready`  in  1  consumer accepts the head event
- `clear_ovf`  in  1  synchronous clear of `overflow`
- `evt_valid`  out  1  head event available
- `evt_code`  out  2  event class of the head event
- `evt_value`  out  SIZE  count value that produced the event
- `evt_ts`  out  TS_W  cycle timestamp of the event (present only with the macro)
- `overflow`  out  1  sticky: an event was dropped

## Operation
- Registers: `prev` (SIZE), `prev_vld` (1), FIFO, `overflow`, and the timestamp counter if enabled.
- Each edge: `prev <= count`, `prev_vld <= 1`.
- While `prev_vld = 0` (first edge after reset), no event is generated.
- Classification is combinational on (`count`, `prev`). An event is pushed only if `prev_vld` and `count != prev`.
- Event codes:
  - WRAP = 01: `prev` is all-ones and `count = 0`.
  - CLEAR = 10: `count = 0`, `prev != 0`, and `prev` is not all-ones.
  - STEP = 00: `count == prev + 1` (mod 2^SIZE), excluding WRAP.
  - JUMP = 11: any other change.
- Priority: WRAP > CLEAR > STEP > JUMP.
- Pushed payload: {code, `count`, ts}.
- Pop occurs when `evt_valid && evt_ready`.
- FIFO full:
  - A push without a simultaneous pop is dropped and `overflow` is set.
  - A push with a simultaneous pop is accepted.
- FIFO empty with a push: the event appears at the head after that edge. There is no same-cycle bypass.
- `overflow` clears when `clear_ovf` is high. If a drop happens in the same cycle, set wins.
- Outputs are stable while `evt_valid && !evt_ready`.

## Timing
- Reset (`rst` low, asynchronous) values:
  - `evt_valid` = 0, `evt_code` = 0, `evt_value` = 0, `evt_ts` = 0, `overflow` = 0.
  - `prev` = 0, `prev_vld` = 0, FIFO pointers = 0, timestamp = 0.
- Reset deassertion is synchronous to `clk` in effect. The first post-reset edge only captures `prev`.
- Latency: if `count` changes after edge E, the event is pushed at E+1 and `evt_valid` is high after E+1 (FIFO previously empty).
- Throughput: one push and one pop per cycle.
- Reset mid-operation discards all buffered events.
- A counter clear that lands on all-ones→0 is reported as WRAP. This is by definition.

## Configuration
- Macro: `COUNT_EVENT_MONITOR_TS_EN`.
- Defined:
  - A free-running TS_W-bit cycle counter increments every edge and wraps at 2^TS_W.
  - Each pushed event stores the counter value before that edge's increment.
  - `evt_ts` port is present.
- Undefined:
  - No timestamp counter and no `evt_ts` port.
  - FIFO entry width is 2+SIZE.

## Structure
- Package `count_event_monitor_pkg`:
  - enum `evt_code_t` {STEP, WRAP, CLEAR, JUMP}.
  - Constant `EVT_CODE_W` = 2.
- Sub-module `event_fifo`:
  - Parameterised WIDTH/DEPTH, synchronous FIFO.
  - Registered head, full/empty flags, push/pop in the same cycle.
- Top contains the classifier, `prev` registers, overflow logic and the optional timestamp counter.

## Test plan
- Reset, then `count` 0→1→2, `evt_ready`=1: events STEP/1 then STEP/2, each `evt_valid` one cycle after the change; no event for the first post-reset sample.
- `count` 14→15→0: STEP/15, then WRAP/0. Separately, `count` 5→0 gives CLEAR/0, and `count` 3→9 gives JUMP/9.
- `count` held at 7 for 10 cycles: `evt_valid` stays 0.
- `evt_ready`=0 with 5 changes at DEPTH=4:
  - Four events are buffered; the 5th is dropped and `overflow`=1.
  - With `clear_ovf` and a new drop in the same cycle, `overflow` stays 1.
  - Raising `evt_ready` drains exactly four events in order.
- Full FIFO with simultaneous push and pop: no drop, order preserved. Assert `rst` low mid-burst: `evt_valid`=0 immediately and the FIFO is empty after release.
- With `COUNT_EVENT_MONITOR_TS_EN`: `evt_ts` of consecutive STEP events at a one-per-cycle count differs by 1, and wraps 65535→0 at the default `TS_W`.
